// File: rtl/mxv_pkg.sv
// Shared types and constants for the matrix-vector frame loader.
// Optional idle-timeout logic in mxv_load_ctrl is enabled by defining MXV_TIMEOUT_EN.
package mxv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_MAT = 2'd1,
        ST_LOAD_VEC = 2'd2,
        ST_READY    = 2'd3
    } state_e;

    localparam int MAT_DIM_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 150000;

    // Frame is a square matrix followed by one vector of the same dimension.
    function automatic int frame_len(input int mat_dim);
        return mat_dim * mat_dim + mat_dim;
    endfunction

    localparam int FRAME_LEN = frame_len(MAT_DIM_DEF);

    localparam int ERR_W       = 3;
    localparam int ERR_PARITY  = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/mxv_frame_buf.sv
// Frame byte store: one synchronous write port, one registered read port
// that returns zero for addresses beyond the frame.
module mxv_frame_buf
    import mxv_pkg::*;
#(
    parameter int DEPTH = FRAME_LEN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto plain RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = 8'h00;
        if ({1'b0, rd_addr} < DEPTH_C) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mxv_load_ctrl.sv
// Collects one UART matrix+vector frame into a buffer and holds it for the CPU.
// Define MXV_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle clocks.
module mxv_load_ctrl
    import mxv_pkg::*;
#(
    parameter int  MAT_DIM        = MAT_DIM_DEF,
    parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    localparam int LEN            = frame_len(MAT_DIM),
    localparam int AW             = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic             rx_parity_err,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data,
    input  logic             frame_ack,
    output logic             frame_ready,
    output logic [1:0]       state_o,
    output logic [ERR_W-1:0] err_flags
);

    localparam logic [AW-1:0] MAT_LAST   = AW'(MAT_DIM * MAT_DIM - 1);
    localparam logic [AW-1:0] FRAME_LAST = AW'(LEN - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             frame_ready_q, frame_ready_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             loading;

    assign loading = (state_q == ST_LOAD_MAT) || (state_q == ST_LOAD_VEC);

`ifdef MXV_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    // Counts idle clocks inside a frame; any byte (or leaving the load states) restarts it.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (loading && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_ready_d = frame_ready_q;
        err_d         = err_q;
        wr_en         = 1'b0;
        wr_addr       = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid && !rx_parity_err) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    cnt_d   = AW'(1);
                    state_d = (MAT_DIM == 1) ? ST_LOAD_VEC : ST_LOAD_MAT;
                end
            end
            ST_LOAD_MAT, ST_LOAD_VEC: begin
                if (rx_valid) begin
                    if (rx_parity_err) begin
                        err_d[ERR_PARITY] = 1'b1;
                        cnt_d             = '0;
                        state_d           = ST_IDLE;
                    end else begin
                        wr_en = 1'b1;
                        if (cnt_q == FRAME_LAST) begin
                            cnt_d         = '0;
                            state_d       = ST_READY;
                            frame_ready_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                            if (cnt_q == MAT_LAST) begin
                                state_d = ST_LOAD_VEC;
                            end
                        end
                    end
                end
            end
            ST_READY: begin
                if (frame_ack) begin
                    state_d       = ST_IDLE;
                    frame_ready_d = 1'b0;
                    err_d         = '0;
                end
                // Overrun is applied after the ack clear so it survives a same-cycle ack.
                if (rx_valid) begin
                    err_d[ERR_OVERRUN] = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef MXV_TIMEOUT_EN
        if (tmo_hit) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            cnt_d              = '0;
            state_d            = ST_IDLE;
        end
`else
        err_d[ERR_TIMEOUT] = 1'b0;
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            frame_ready_q <= 1'b0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_ready_q <= frame_ready_d;
            err_q         <= err_d;
        end
    end

    mxv_frame_buf #(
        .DEPTH (LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (rx_byte),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign state_o     = state_q;
    assign frame_ready = frame_ready_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_mxv_load_ctrl.sv
// Self-checking bench for mxv_load_ctrl: frame-level reference model plus directed scenarios.
// Expectations for the timeout scenario follow whether MXV_TIMEOUT_EN is defined.
module tb_mxv_load_ctrl;

    localparam int MAT_DIM = 4;
    localparam int LEN     = 20;
    localparam int AW      = 5;
    localparam int TMO     = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_parity_err;
    logic [AW-1:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic       frame_ready;
    logic [1:0] state_o;
    logic [2:0] err_flags;

    always #5 clk = ~clk;

    mxv_load_ctrl #(
        .MAT_DIM        (MAT_DIM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_ack     (frame_ack),
        .frame_ready   (frame_ready),
        .state_o       (state_o),
        .err_flags     (err_flags)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the list of bytes received so far; the held frame is a flag.
    logic [7:0] mbuf [LEN];
    bit         mknown [LEN];
    logic [7:0] cur [$];
    bit         holding  = 1'b0;
    logic [2:0] merr     = 3'b000;
    int         idle     = 0;
    logic [7:0] rd_exp   = 8'h00;
    bit         rd_known = 1'b0;
    bit         model_on = 1'b0;

    function automatic logic [1:0] model_state();
        if (holding)                 return 2'd3;
        if (cur.size() == 0)         return 2'd0;
        if (cur.size() < MAT_DIM*MAT_DIM) return 2'd1;
        return 2'd2;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cur.delete();
            holding  = 1'b0;
            merr     = 3'b000;
            idle     = 0;
            rd_exp   = 8'h00;
            rd_known = 1'b1;
            model_on = 1'b1;
        end else if (model_on) begin
            if (int'(rd_addr) < LEN) begin
                rd_exp   = mbuf[rd_addr];
                rd_known = mknown[rd_addr];
            end else begin
                rd_exp   = 8'h00;
                rd_known = 1'b1;
            end
            if (holding) begin
                if (frame_ack) begin
                    holding = 1'b0;
                    merr    = 3'b000;
                end
                if (rx_valid) merr[1] = 1'b1;
            end else if (rx_valid) begin
                if (rx_parity_err) begin
                    if (cur.size() > 0) begin
                        merr[0] = 1'b1;
                        cur.delete();
                    end
                end else begin
                    mbuf[cur.size()]   = rx_byte;
                    mknown[cur.size()] = 1'b1;
                    cur.push_back(rx_byte);
                    if (cur.size() == LEN) begin
                        holding = 1'b1;
                        cur.delete();
                    end
                end
                idle = 0;
            end else if (cur.size() > 0) begin
                idle++;
`ifdef MXV_TIMEOUT_EN
                if (idle == TMO) begin
                    merr[2] = 1'b1;
                    cur.delete();
                    idle = 0;
                end
`endif
            end else begin
                idle = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_state_o", 32'(state_o), 32'(model_state()));
            check("cyc_frame_ready", 32'(frame_ready), 32'(holding));
            check("cyc_err_flags", 32'(err_flags), 32'(merr));
            if (rd_known) check("cyc_rd_data", 32'(rd_data), 32'(rd_exp));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        rx_byte       = b;
        rx_parity_err = p;
        rx_valid      = 1'b1;
        tick();
        rx_valid      = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    // kind 0: 0x01..0x10 then 0x01..0x04; otherwise base+i
    function automatic logic [7:0] frame_byte(input int kind, input logic [7:0] base, input int i);
        if (kind == 0) return (i < 16) ? 8'(i + 1) : 8'(i - 15);
        return base + 8'(i);
    endfunction

    task automatic send_frame(input int kind, input logic [7:0] base);
        for (int i = 0; i < LEN; i++) send(frame_byte(kind, base, i), 1'b0);
    endtask

    task automatic read_check(input string name, input int a, input logic [7:0] exp);
        rd_addr = AW'(a);
        tick();
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        rx_byte       = 8'h00;
        rx_valid      = 1'b0;
        rx_parity_err = 1'b0;
        rd_addr       = '0;
        frame_ack     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ready", 32'(frame_ready), 32'd0);
        check("rst_err", 32'(err_flags), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);

        // Full frame and readback, including out-of-range addresses
        send_frame(0, 8'h00);
        check("t1_ready", 32'(frame_ready), 32'd1);
        check("t1_state", 32'(state_o), 32'd3);
        check("t1_err", 32'(err_flags), 32'd0);
        for (int a = 0; a < LEN; a++) read_check("t1_rd", a, frame_byte(0, 8'h00, a));
        read_check("t1_rd20", 20, 8'h00);
        read_check("t1_rd31", 31, 8'h00);
        ack();
        check("t1_ack_state", 32'(state_o), 32'd0);
        check("t1_ack_ready", 32'(frame_ready), 32'd0);

        // Parity error drops partial frame; next frame loads normally
        for (int i = 0; i < 5; i++) send(8'h21 + 8'(i), 1'b0);
        send(8'h26, 1'b1);
        check("t2_par_state", 32'(state_o), 32'd0);
        check("t2_par_err", 32'(err_flags), 32'b001);
        send_frame(1, 8'h40);
        check("t2_state", 32'(state_o), 32'd3);
        check("t2_err_sticky", 32'(err_flags), 32'b001);
        read_check("t2_rd5", 5, 8'h45);
        read_check("t2_rd19", 19, 8'h53);
        ack();
        check("t2_ack_err", 32'(err_flags), 32'd0);

        // Overrun while holding a frame
        send_frame(0, 8'h00);
        send(8'hAA, 1'b0);
        check("t3_ovr_err", 32'(err_flags), 32'b010);
        check("t3_ovr_state", 32'(state_o), 32'd3);
        read_check("t3_rd0", 0, 8'h01);
        ack();
        check("t3_ack_state", 32'(state_o), 32'd0);
        check("t3_ack_err", 32'(err_flags), 32'd0);

        // Simultaneous ack and byte in READY
        send_frame(1, 8'h80);
        rd_addr   = '0;
        frame_ack = 1'b1;
        rx_byte   = 8'h55;
        rx_valid  = 1'b1;
        tick();
        frame_ack = 1'b0;
        rx_valid  = 1'b0;
        check("t4_state", 32'(state_o), 32'd0);
        check("t4_err", 32'(err_flags), 32'b010);
        check("t4_ready", 32'(frame_ready), 32'd0);
        tick();
        check("t4_rd0", 32'(rd_data), 32'h80);

        // Idle timeout on a partial frame
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 1'b0);
        repeat (TMO - 1) tick();
        check("t5_pre_state", 32'(state_o), 32'd1);
        tick();
`ifdef MXV_TIMEOUT_EN
        check("t5_state", 32'(state_o), 32'd0);
        check("t5_err", 32'(err_flags), 32'b100);
`else
        check("t5_state", 32'(state_o), 32'd1);
        check("t5_err", 32'(err_flags), 32'b000);
`endif

        // Reset mid-load, then a fresh frame starts at index 0
        do_reset();
        for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), 1'b0);
        rd_addr = AW'(3);
        rst = 1'b1;
        tick();
        check("t6_rst_state", 32'(state_o), 32'd0);
        check("t6_rst_ready", 32'(frame_ready), 32'd0);
        check("t6_rst_err", 32'(err_flags), 32'd0);
        check("t6_rst_rd", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();
        ack();
        check("t6_ack_idle", 32'(state_o), 32'd0);
        for (int i = 0; i < 15; i++) send(8'hC0 + 8'(i), 1'b0);
        check("t6_mat_state", 32'(state_o), 32'd1);
        ack();
        check("t6_ack_load", 32'(state_o), 32'd1);
        send(8'hCF, 1'b0);
        check("t6_vec_state", 32'(state_o), 32'd2);
        for (int i = 16; i < LEN; i++) send(8'hC0 + 8'(i), 1'b0);
        check("t6_ready_state", 32'(state_o), 32'd3);
        read_check("t6_rd0", 0, 8'hC0);
        read_check("t6_rd9", 9, 8'hC9);
        read_check("t6_rd16", 16, 8'hD0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
